// File: rtl/chan_req_agent.sv
// Per-port ingress buffer that requests the channel arbiter once a complete packet is stored.
// Optional statistics outputs are enabled with `define CHAN_REQ_AGENT_STAT_EN.
module chan_req_agent #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  output logic                  o_ready,
  output logic                  o_chan_req,
  input  logic                  i_chan_resp,
  input  logic                  i_chan_nresp,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_end,
  output logic                  o_err
`ifdef CHAN_REQ_AGENT_STAT_EN
  ,
  output logic [15:0]           o_grant_cnt,
  output logic [15:0]           o_lose_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  word_cnt, pkt_cnt;
  logic [1:0]            state;
  logic                  in_pkt, discard;
  logic                  accept, wr_en, rd_en, oversize, pkt_inc, pkt_dec, err_event;
  logic [DATA_WIDTH:0]   rd_word;

  assign o_ready = (word_cnt < FULL);

  always_comb begin
    accept    = i_valid && o_ready;
    wr_en     = accept && !discard;
    rd_en     = ((state == S_REQ) && i_chan_resp) || ((state == S_SEND) && !o_end);
    rd_word   = mem[rd_ptr];
    oversize  = (word_cnt == FULL) && (pkt_cnt == '0);
    pkt_inc   = wr_en && i_eop;
    pkt_dec   = rd_en && rd_word[DATA_WIDTH];
    err_event = (i_chan_resp && (state != S_REQ)) || (accept && i_sop && in_pkt) || oversize;
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= {i_eop, i_data};
  end

  // A full FIFO holding no complete packet can never drain: drop it and skip to the next eop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
      in_pkt   <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (oversize) begin
        rd_ptr   <= wr_ptr;
        word_cnt <= '0;
        discard  <= 1'b1;
        in_pkt   <= 1'b0;
      end else begin
        if (rd_en) rd_ptr <= rd_ptr + AW'(1);
        word_cnt <= word_cnt + (wr_en ? ONE : '0) - (rd_en ? ONE : '0);
        if (accept) begin
          if (discard) begin
            if (i_eop) discard <= 1'b0;
          end else begin
            in_pkt <= !i_eop;
          end
        end
      end
      if (pkt_inc && !pkt_dec)      pkt_cnt <= pkt_cnt + ONE;
      else if (pkt_dec && !pkt_inc) pkt_cnt <= pkt_cnt - ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_chan_req <= 1'b0;
      o_valid    <= 1'b0;
      o_end      <= 1'b0;
      o_data     <= '0;
      o_err      <= 1'b0;
    end else begin
      o_err <= err_event;
      case (state)
        S_IDLE: begin
          if (pkt_cnt != '0) begin
            state      <= S_REQ;
            o_chan_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (i_chan_resp) begin
            state      <= S_SEND;
            o_chan_req <= 1'b0;
            o_valid    <= 1'b1;
            o_data     <= rd_word[DATA_WIDTH-1:0];
            o_end      <= rd_word[DATA_WIDTH];
          end else if (i_chan_nresp) begin
            state      <= S_REQ;
            o_chan_req <= 1'b1;
          end
        end
        S_SEND: begin
          // Re-request straight from the end-of-packet cycle when more packets wait.
          if (o_end) begin
            o_valid <= 1'b0;
            o_end   <= 1'b0;
            if (pkt_cnt != '0) begin
              state      <= S_REQ;
              o_chan_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            o_data <= rd_word[DATA_WIDTH-1:0];
            o_end  <= rd_word[DATA_WIDTH];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CHAN_REQ_AGENT_STAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_cnt <= '0;
      o_lose_cnt  <= '0;
    end else if (state == S_REQ) begin
      if (i_chan_resp && (o_grant_cnt != '1))  o_grant_cnt <= o_grant_cnt + 16'd1;
      if (i_chan_nresp && (o_lose_cnt != '1))  o_lose_cnt  <= o_lose_cnt + 16'd1;
    end
  end
`endif

endmodule
